vp_text_serializer: RTL
=======================

// Module: vp_text_serializer
// PURPOSE
//   Consumes the delayed per-character text attributes and turns each character slot into a
//   stream of 4-bit colour indexes, one pixel per clock, MSB first.
//   Sits directly downstream of the text attribute delay stage in the video pipeline.
//   Handles double width, blink, invert, underline and border masks.
//   A 1-entry holding register gives gap-free back-to-back characters.
// PARAMETERS
//   CHAR_WIDTH    16  pixels per slot; equals the pattern and border mask width
//   BLINK_FRAMES  32  frame_start pulses per blink half-period (>=1)
// PORTS
//   clk             in   1   pixel clock
//   reset_n         in   1   synchronous reset, active low
//   in_valid        in   1   character slot offered
//   in_ready        out  1   slot accepted when in_valid && in_ready
//   txt_foreground  in   4   foreground colour index
//   txt_background  in   4   background colour index
//   txt_horz_size   in   1   1 = double width
//   txt_horz_part   in   1   double-width half: 0 = bits[15:8], 1 = bits[7:0]
//   txt_pattern     in   16  glyph row, bit 15 = leftmost pixel
//   txt_border      in   16  border mask, same bit order
//   txt_func        in   2   00 pattern, 01 border, 10 pattern|border, 11 solid bg
//   txt_blink       in   1   character blinks
//   txt_invert      in   1   swap fg/bg
//   txt_underline   in   1   character underlined
//   txt_enable      in   1   0 = slot blanked
//   underline_row   in   1   current scanline is the underline row; sampled with the slot
//   frame_start     in   1   1-cycle pulse per frame; advances blink timer
//   pix_valid       out  1   pix_color valid this cycle
//   pix_color       out  4   colour index
// BEHAVIOUR
//   Reset (reset_n=0 at clk edge):
//     - shifter, holding reg, blink counter, pix_valid, pix_color = 0
//     - blink_phase = 1 (visible), in_ready = 0
//     - in_ready = 1 on the first cycle after release
//   States: IDLE (shifter empty) and SHIFT (pixel count 0..CHAR_WIDTH-1).
//   Holding register:
//     - in_ready = !hold_full
//     - accept loads hold; hold moves to the shifter when shifter empty or on last pixel
//     - accept and shifter-load in the same cycle is legal; hold refills
//   Latency:
//     - slot accepted at edge N with shifter IDLE -> first pixel pix_valid=1 after edge N+1
//     - next slot pixel 0 immediately follows previous pixel CHAR_WIDTH-1 if hold full: no gap
//   Underflow: shifter empty and hold empty -> pix_valid=0, pix_color=0.
//   Pixel bit b at count c:
//     - single width: b = mask[CHAR_WIDTH-1-c]
//     - double width: b = half[7 - c/2], half selected by horz_part; each bit emitted twice
//   on (per func):
//     - 00 -> pattern bit
//     - 01 -> border bit
//     - 10 -> pattern | border
//     - 11 -> on = 0
//   Modifiers, applied in order:
//     - underline && underline_row -> on = 1
//     - blink && !blink_phase -> on = 0
//     - invert -> on = !on
//   pix_color = on ? foreground : background; txt_enable=0 -> pix_color = 0, pix_valid still 1.
//   All attributes are latched at acceptance; input changes mid-slot have no effect.
//   Blink timer:
//     - frame_start increments a counter; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase
//     - frame_start during reset is ignored
//   Reset mid-slot: remaining pixels discarded, hold cleared, no partial output after release.
// TESTING
//   Single width: pattern 0xA5F0, fg 0xF, bg 0x1, func 00 -> colours F,1,F,1,1,F,1,F,F,F,F,F,1,1,1,1.
//   Double width: pattern 0x00FF, part 1, fg 0x7, bg 0x0 -> 16 pixels of 0x7.
//   Double width: same pattern, part 0 -> 16 pixels of 0x0.
//   Back-to-back: 3 slots with in_valid held high -> 48 consecutive pix_valid.
//     - in_ready drops while hold is full
//     - no bubble between slots
//   Blink with BLINK_FRAMES=2, blink=1, pattern 0xFFFF, fg 0xC, bg 0x2:
//     - frames 0-1 -> all 0xC
//     - frames 2-3 -> all 0x2
//     - invert=1 swaps these results
//   Underline + func 11, underline_row=1 -> all fg; txt_enable=0 -> all 0x0 with pix_valid=1.
//   Reset at pixel 5 of a slot with hold full:
//     - pix_valid=0 the cycle after
//     - in_ready=1 one cycle after release
//     - next slot starts at pixel 0

Source files
------------

// File: rtl/vp_text_serializer.sv
// vp_text_serializer
//   Turns accepted text character slots into a stream of 4-bit colour
//   indexes, one pixel per clock, leftmost pixel first. A one-entry holding
//   register sits in front of the pixel shifter, so a slot that is waiting
//   is loaded on the last pixel of the current slot without a gap.
//   The stream supports double width, blink, invert, underline and border masks.
//
// Ports
//   clk, reset_n        pixel clock, synchronous active-low reset
//   in_valid/in_ready   slot handshake (accepted when both high)
//   txt_*               per-slot attributes, latched at acceptance
//   underline_row       current scanline is the underline row, latched with the slot
//   frame_start         one-cycle pulse per frame, drives the blink timer
//   pix_valid/pix_color pixel output stream (colour 0 when no pixel is valid)
module vp_text_serializer #(
  parameter int CHAR_WIDTH   = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            txt_foreground,
  input  logic [3:0]            txt_background,
  input  logic                  txt_horz_size,
  input  logic                  txt_horz_part,
  input  logic [CHAR_WIDTH-1:0] txt_pattern,
  input  logic [CHAR_WIDTH-1:0] txt_border,
  input  logic [1:0]            txt_func,
  input  logic                  txt_blink,
  input  logic                  txt_invert,
  input  logic                  txt_underline,
  input  logic                  txt_enable,
  input  logic                  underline_row,
  input  logic                  frame_start,
  output logic                  pix_valid,
  output logic [3:0]            pix_color
);

  localparam int CW = (CHAR_WIDTH > 1) ? $clog2(CHAR_WIDTH) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(CHAR_WIDTH - 1);
  localparam logic [CW-1:0] HALF_TOP  = CW'(CHAR_WIDTH / 2 - 1);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [3:0]            fg;
    logic [3:0]            bg;
    logic                  dbl;
    logic                  part;
    logic [CHAR_WIDTH-1:0] pattern;
    logic [CHAR_WIDTH-1:0] border;
    logic [1:0]            func;
    logic                  blink;
    logic                  invert;
    logic                  underline;
    logic                  enable;
    logic                  uline_row;
  } slot_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Mask bit for pixel count cnt. In double width each half-mask bit is
  // shown for two consecutive pixels.
  function automatic logic pick_bit(input logic [CHAR_WIDTH-1:0] mask,
                                    input logic dbl, input logic part,
                                    input logic [CW-1:0] cnt);
    logic [CW-1:0] idx;
    if (dbl) idx = (part ? HALF_TOP : LAST_CNT) - (cnt >> 1);
    else     idx = LAST_CNT - cnt;
    return mask[idx];
  endfunction

  // Modifier order matters: underline forces on, blink-off then forces it
  // off, invert is applied last so an inverted blinking glyph shows fg.
  function automatic logic [3:0] slot_color(input slot_t s, input logic [CW-1:0] cnt,
                                            input logic phase);
    logic       on;
    logic       pb;
    logic       bb;
    logic [3:0] col;
    pb = pick_bit(s.pattern, s.dbl, s.part, cnt);
    bb = pick_bit(s.border, s.dbl, s.part, cnt);
    case (s.func)
      2'b00:   on = pb;
      2'b01:   on = bb;
      2'b10:   on = pb | bb;
      default: on = 1'b0;
    endcase
    if (s.underline && s.uline_row) on = 1'b1;
    if (s.blink && !phase)          on = 1'b0;
    if (s.invert)                   on = !on;
    col = on ? s.fg : s.bg;
    if (!s.enable) col = 4'h0;
    return col;
  endfunction

  slot_t         in_slot;
  slot_t         hold_p0;
  logic          hold_full_p0;
  slot_t         shift_p1;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_p1, cnt_d;
  logic          ready_en;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          accept;
  logic          last_pix;
  logic          load_shift;

  always_comb begin
    in_slot           = '0;
    in_slot.fg        = txt_foreground;
    in_slot.bg        = txt_background;
    in_slot.dbl       = txt_horz_size;
    in_slot.part      = txt_horz_part;
    in_slot.pattern   = txt_pattern;
    in_slot.border    = txt_border;
    in_slot.func      = txt_func;
    in_slot.blink     = txt_blink;
    in_slot.invert    = txt_invert;
    in_slot.underline = txt_underline;
    in_slot.enable    = txt_enable;
    in_slot.uline_row = underline_row;
  end

  // ready_en keeps in_ready low while in reset and releases it one edge later
  assign in_ready   = ready_en && !hold_full_p0;
  assign accept     = in_valid && in_ready;
  assign last_pix   = (state_q == SHIFT) && (cnt_p1 == LAST_CNT);
  assign load_shift = hold_full_p0 && ((state_q == IDLE) || last_pix);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_p1  <= '0;
    end else begin
      state_q <= state_d;
      cnt_p1  <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_p1;
    case (state_q)
      IDLE: begin
        if (load_shift) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last_pix) begin
          cnt_d = '0;
          if (!load_shift) state_d = IDLE;
        end else begin
          cnt_d = cnt_p1 + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage p0: holding register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_p0      <= '0;
      hold_full_p0 <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      if (accept) hold_p0 <= in_slot;
      hold_full_p0 <= accept || (hold_full_p0 && !load_shift);
    end
  end

  // Stage p1: pixel shifter attributes
  always_ff @(posedge clk) begin
    if (!reset_n) shift_p1 <= '0;
    else if (load_shift) shift_p1 <= hold_p0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_TOP) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign pix_valid = (state_q == SHIFT);
  assign pix_color = pix_valid ? slot_color(shift_p1, cnt_p1, blink_phase) : 4'h0;

endmodule
